// File: rtl/ls_seq_pkg.sv
// Shared types and helpers for the LOAD/STORE copy sequencer.
// Holds the FSM state type, default widths and the round-robin pick.
package ls_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE,
    WAIT
  } ls_state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW      = 8;
  localparam int DEF_DW      = 32;
  localparam int DEF_LW      = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int MAX_REQ     = 8;
  localparam int IW          = 3;

  // First valid requester at or after ptr, wrapping at n.
  function automatic logic [IW-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [IW-1:0]      ptr,
    input int unsigned        n
  );
    logic [IW-1:0] win;
    logic          hit;
    int unsigned   j;
    win = ptr;
    hit = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = (32'(ptr) + i) % n;
      if (i < n && !hit && valid[j[IW-1:0]]) begin
        win = j[IW-1:0];
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ls_xfer_sequencer_if.sv
// Requester and memory-side signal bundle of the copy sequencer.
// master = sequencer side, slave = requesters plus memory.
interface ls_xfer_sequencer_if #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int LW      = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_src;
  logic [NUM_REQ*AW-1:0] req_dst;
  logic [NUM_REQ*LW-1:0] req_len;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  busy;
  logic                  mem_rd_en;
  logic [AW-1:0]         mem_rd_addr;
  logic [DW-1:0]         mem_rd_data;
  logic                  mem_rd_valid;
  logic                  mem_wr_en;
  logic [AW-1:0]         mem_wr_addr;
  logic [DW-1:0]         mem_wr_data;
  logic                  mem_wr_ack;
  logic                  timeout_err;

  modport master (
    input  req_valid, req_src, req_dst, req_len,
    input  mem_rd_data, mem_rd_valid, mem_wr_ack,
    output grant, done, busy,
    output mem_rd_en, mem_rd_addr,
    output mem_wr_en, mem_wr_addr, mem_wr_data,
    output timeout_err
  );

  modport slave (
    output req_valid, req_src, req_dst, req_len,
    output mem_rd_data, mem_rd_valid, mem_wr_ack,
    input  grant, done, busy,
    input  mem_rd_en, mem_rd_addr,
    input  mem_wr_en, mem_wr_addr, mem_wr_data,
    input  timeout_err
  );
endinterface

// File: rtl/ls_rr_arbiter.sv
// Round-robin arbiter: request vector plus start pointer to
// one-hot grant and winner index.
import ls_seq_pkg::*;

module ls_rr_arbiter #(
  parameter int N = DEF_NUM_REQ
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  assign any_o = |req_i;
  assign idx_o = rr_pick(MAX_REQ'(req_i), ptr_i, N);
  assign gnt_o = any_o ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/ls_xfer_sequencer.sv
// Round-robin memory-copy sequencer: LOAD -> STORE -> WAIT per word.
// Optional stall abort in LOAD/WAIT enabled by LS_SEQ_TIMEOUT_EN.
import ls_seq_pkg::*;

module ls_xfer_sequencer #(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int LW             = DEF_LW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input logic                 clock,
  input logic                 resetn,
  ls_xfer_sequencer_if.master bus
);

  ls_state_t          state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      own_q;
  logic [AW-1:0]      src_q;
  logic [AW-1:0]      dst_q;
  logic [LW-1:0]      rem_q;
  logic [DW-1:0]      data_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               rd_en_q;
  logic               wr_en_q;
  logic               zdone_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [NUM_REQ-1:0] own_oh;
  logic [LW-1:0]      win_len;
  logic [IW-1:0]      ptr_d;

  ls_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign own_oh  = NUM_REQ'(1) << own_q;
  assign win_len = bus.req_len[arb_idx*LW +: LW];
  assign ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

`ifdef LS_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_q;
  logic          tmo_q;
  logic          stalled;

  assign stalled = (state_q == LOAD && !bus.mem_rd_valid) ||
                   (state_q == WAIT && !bus.mem_wr_ack);
  assign bus.timeout_err = tmo_q;
`else
  assign bus.timeout_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      zdone_q <= 1'b0;
`ifdef LS_SEQ_TIMEOUT_EN
      stall_q <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      wr_en_q <= 1'b0;
      zdone_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Zero-length job: done owed this cycle, no arbitration.
          if (zdone_q) begin
            done_q <= own_oh;
          end else if (arb_any) begin
            grant_q <= arb_gnt;
            own_q   <= arb_idx;
            ptr_q   <= ptr_d;
            src_q   <= bus.req_src[arb_idx*AW +: AW];
            dst_q   <= bus.req_dst[arb_idx*AW +: AW];
            rem_q   <= win_len;
            if (win_len == '0) begin
              zdone_q <= 1'b1;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.mem_rd_valid) begin
            data_q  <= bus.mem_rd_data;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b1;
            state_q <= STORE;
          end
        end
        STORE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.mem_wr_ack) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LW'(1)) begin
              done_q  <= own_oh;
              state_q <= IDLE;
            end else begin
              src_q   <= src_q + 1'b1;
              dst_q   <= dst_q + 1'b1;
              rd_en_q <= 1'b1;
              state_q <= LOAD;
            end
          end
        end
      endcase
`ifdef LS_SEQ_TIMEOUT_EN
      tmo_q <= 1'b0;
      if (stalled) begin
        if (stall_q == TW'(TIMEOUT_CYCLES - 1)) begin
          stall_q <= '0;
          tmo_q   <= 1'b1;
          done_q  <= own_oh;
          rd_en_q <= 1'b0;
          state_q <= IDLE;
        end else begin
          stall_q <= stall_q + 1'b1;
        end
      end else begin
        stall_q <= '0;
      end
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = src_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = dst_q;
  assign bus.mem_wr_data = data_q;

endmodule
